// File: rtl/iceboard_uart_rx.sv
// rtl/iceboard_uart_rx.sv - 8N1 UART receiver with mid-bit sampling and FWFT byte FIFO
module iceboard_uart_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx,
    output logic                          rx_receive,
    output logic [7:0]                    data,
    output logic                          valid,
    input  logic                          ready,
    output logic                          frame_error,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_STOP      = 3'd3;
    localparam logic [2:0] S_WAIT_IDLE = 3'd4;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic [2:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2:0]             bit_q, bit_d;
    logic [7:0]             shift_q, shift_d;
    logic                   push_q, push_d;
    logic                   ferr_q, ferr_d;
    logic                   ovr_q;

    logic [7:0]             mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]       level_q;
    logic                   full, pop, accept;

    assign rx_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        push_d  = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                // Restarting the counter at mid start bit puts every later sample mid-bit.
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        push_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT_IDLE: begin
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            push_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            push_q  <= push_d;
            ferr_q  <= ferr_d;
        end
    end

    assign full   = (level_q == LVL_W'(FIFO_DEPTH));
    assign pop    = valid && ready;
    assign accept = push_q && (!full || pop);

    // shift_q holds the finished byte until the next frame's first data sample.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovr_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(accept);
            rd_ptr_q <= rd_ptr_q + PTR_W'(pop);
            level_q  <= level_q + LVL_W'(accept) - LVL_W'(pop);
            ovr_q    <= push_q && full && !pop;
        end
    end

    assign valid       = (level_q != '0);
    assign data        = valid ? mem_q[rd_ptr_q] : 8'h00;
    assign fifo_level  = level_q;
    assign frame_error = ferr_q;
    assign overrun     = ovr_q;
    assign rx_receive  = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP);

endmodule

// File: tb/tb_iceboard_uart_rx.sv
// tb/tb_iceboard_uart_rx.sv - self-checking bench for iceboard_uart_rx
module tb_iceboard_uart_rx;

    localparam int CPB   = 16;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       ready;
    logic       rx_receive;
    logic [7:0] data;
    logic       valid;
    logic       frame_error;
    logic       overrun;
    logic [4:0] fifo_level;

    iceboard_uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .rx(rx), .rx_receive(rx_receive), .data(data),
        .valid(valid), .ready(ready), .frame_error(frame_error), .overrun(overrun),
        .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int fe_cnt = 0, ov_cnt = 0, rr_cnt = 0, max_level = 0;
    int exp_fe = 0, exp_ov = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (valid && ready) got_q.push_back(data);
            if (frame_error) fe_cnt++;
            if (overrun) ov_cnt++;
            if (rx_receive) rr_cnt++;
            if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Model: a good frame enters the stream unless the FIFO would already hold DEPTH bytes.
    task automatic send_byte(input logic [7:0] b, input logic stop_val, input int stop_len);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = stop_val;
        tick(stop_len * CPB);
        if (!stop_val) begin
            rx = 1'b1;
            tick(CPB);
            exp_fe++;
        end else if (exp_q.size() - got_q.size() < DEPTH) begin
            exp_q.push_back(b);
        end else begin
            exp_ov++;
        end
    endtask

    task automatic drain();
        ready = 1'b1;
        for (int k = 0; k < 4 * DEPTH && valid; k++) tick(1);
        ready = 1'b0;
        tick(1);
        check("drain_empty", valid, 1'b0);
    endtask

    task automatic compare_stream(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        int n;
        logic [7:0] b;
        reset = 1'b1;
        rx    = 1'b1;
        ready = 1'b0;
        tick(4);
        check("rst_valid", valid, 1'b0);
        check("rst_data", data, 8'h00);
        check("rst_level", fifo_level, 0);
        check("rst_rx_receive", rx_receive, 1'b0);
        check("rst_ferr", frame_error, 1'b0);
        check("rst_ovr", overrun, 1'b0);
        reset = 1'b0;
        tick(2 * CPB);

        rr_cnt = 0;
        send_byte(8'hA5, 1'b1, 1);
        tick(2);
        check("t1_valid", valid, 1'b1);
        check("t1_data", data, 8'hA5);
        check("t1_level", fifo_level, 1);
        check("t1_busy_cycles", rr_cnt, 9 * CPB + CPB / 2);
        check("t1_rx_receive_idle", rx_receive, 1'b0);
        drain();
        compare_stream("t1");

        rr_cnt = 0;
        rx = 1'b0;
        tick(CPB / 4);
        rx = 1'b1;
        tick(2 * CPB);
        check("t2_busy_cycles", rr_cnt, CPB / 2);
        check("t2_rx_receive", rx_receive, 1'b0);
        check("t2_level", fifo_level, 0);
        check("t2_ferr", fe_cnt, 0);

        send_byte(8'h3C, 1'b0, 3);
        check("t3_ferr", fe_cnt, exp_fe);
        check("t3_level", fifo_level, 0);
        send_byte(8'h55, 1'b1, 1);
        tick(2);
        check("t3_level_after", fifo_level, 1);
        drain();
        compare_stream("t3");

        for (int i = 0; i <= DEPTH; i++) send_byte(8'(i), 1'b1, 1);
        tick(2);
        check("t4_overrun", ov_cnt, exp_ov);
        check("t4_level", fifo_level, DEPTH);
        drain();
        compare_stream("t4");

        ready = 1'b1;
        max_level = 0;
        send_byte(8'h11, 1'b1, 1);
        send_byte(8'h22, 1'b1, 1);
        send_byte(8'h33, 1'b1, 1);
        tick(4);
        ready = 1'b0;
        check("t5_max_level_le1", max_level <= 1, 1'b1);
        compare_stream("t5");

        send_byte(8'h42, 1'b1, 1);
        tick(2);
        check("t6_level_pre", fifo_level, 1);
        rx = 1'b0;
        tick(CPB);
        b = 8'h77;
        for (int i = 0; i < 3; i++) begin
            rx = b[i];
            tick(CPB);
        end
        tick(CPB / 2);
        check("t6_busy_pre", rx_receive, 1'b1);
        reset = 1'b1;
        tick(2);
        check("t6_valid", valid, 1'b0);
        check("t6_data", data, 8'h00);
        check("t6_level", fifo_level, 0);
        check("t6_rx_receive", rx_receive, 1'b0);
        rx = 1'b1;
        reset = 1'b0;
        exp_q.delete();
        got_q.delete();
        tick(CPB);
        send_byte(8'h81, 1'b1, 1);
        drain();
        compare_stream("t6");

        n = $urandom_range(1, DEPTH - 1);
        for (int i = 0; i < n; i++) send_byte(8'($urandom), 1'b1, 1);
        tick(2);
        check("rnd_level", fifo_level, n);
        drain();
        compare_stream("rnd_fill");

        ready = 1'b1;
        for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b1, 1);
        tick(4);
        ready = 1'b0;
        compare_stream("rnd_stream");

        check("final_ferr", fe_cnt, exp_fe);
        check("final_ovr", ov_cnt, exp_ov);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
